// File: rtl/adma_pkg.sv
// Shared types and constants for the ADMA Wishbone master arbiter.
package adma_pkg;

  // Requester indices on the shared master port
  localparam int REQ_DESC = 0;
  localparam int REQ_SRC  = 1;
  localparam int REQ_DST  = 2;

  // Bus watchdog counter width
  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/adma_wbm_arb_if.sv
// Bundle of requester-side and master-side Wishbone signals around the arbiter.
// master: the arbiter's view; slave: the environment (requesters + bus slave).
interface adma_wbm_arb_if
  import adma_pkg::*;
#(
  parameter int N_REQ = 3
);
  // requester side
  logic [N_REQ-1:0]    req_cyc_i;
  logic [N_REQ-1:0]    req_stb_i;
  logic [N_REQ-1:0]    req_we_i;
  logic [N_REQ-1:0]    req_cab_i;
  logic [32*N_REQ-1:0] req_adr_i;
  logic [4*N_REQ-1:0]  req_sel_i;
  logic [32*N_REQ-1:0] req_dat_i;
  logic [32*N_REQ-1:0] req_dat64_i;
  logic [N_REQ-1:0]    req_gnt_o;
  logic [N_REQ-1:0]    req_ack_o;
  logic [N_REQ-1:0]    req_err_o;
  logic [N_REQ-1:0]    req_rty_o;
  logic [31:0]         req_dat_o;
  logic [31:0]         req_dat64_o;

  // external master port
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic                wbm_cab_o;
  logic [31:0]         wbm_adr_o;
  logic [3:0]          wbm_sel_o;
  logic [31:0]         wbm_dat_o;
  logic [31:0]         wbm_dat64_o;
  logic                wbm_ack_i;
  logic                wbm_err_i;
  logic                wbm_rty_i;
  logic [31:0]         wbm_dat_i;
  logic [31:0]         wbm_dat64_i;

  modport master (
    input  req_cyc_i, req_stb_i, req_we_i, req_cab_i,
    input  req_adr_i, req_sel_i, req_dat_i, req_dat64_i,
    output req_gnt_o, req_ack_o, req_err_o, req_rty_o,
    output req_dat_o, req_dat64_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
    output wbm_adr_o, wbm_sel_o, wbm_dat_o, wbm_dat64_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
  );

  modport slave (
    output req_cyc_i, req_stb_i, req_we_i, req_cab_i,
    output req_adr_i, req_sel_i, req_dat_i, req_dat64_i,
    input  req_gnt_o, req_ack_o, req_err_o, req_rty_o,
    input  req_dat_o, req_dat64_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o,
    input  wbm_adr_o, wbm_sel_o, wbm_dat_o, wbm_dat64_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i, wbm_dat64_i
  );

endinterface

// File: rtl/adma_rr_pick.sv
// Combinational round-robin selector: first requester strictly after the
// one-hot 'last' position wins, wrapping around to index 0.
module adma_rr_pick
  import adma_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic [N_REQ-1:0] upper;
  logic             past_last;
  logic             found;

  // mask of positions above the previous winner
  always_comb begin
    upper     = '0;
    past_last = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      upper[j] = past_last;
      if (last_i[j]) past_last = 1'b1;
    end
  end

  // lowest request above last, else lowest request overall (wrap)
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_i[j] && upper[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adma_wbm_arb.sv
// Round-robin arbiter for the ADMA 64-bit Wishbone master port, with a
// per-grant beat cap (retry when others wait) and a bus watchdog.
//
// state | meaning
// IDLE  | no owner; grant first requester after last
// OWN   | one requester owns the master port
// GAP   | one cycle with cyc low and no grant; doubles as the next grant decision
module adma_wbm_arb
  import adma_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_BEATS = 16,
  parameter int TMO_CYC   = 255
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  adma_wbm_arb_if.master bus,
  input  logic           tmo_clr_i,
  output logic           arb_tmo_o
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  last_q, last_d;
  logic [N_REQ-1:0]  pick;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              tmo_q, tmo_d;

  logic              own_cyc, own_stb, own_we, own_cab;
  logic [31:0]       own_adr, own_dat, own_dat64;
  logic [3:0]        own_sel;

  logic              in_own, own_busy, others_wait, cap_hit;
  logic              cap_fire, tmo_fire, stb_out, term;

  adma_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (bus.req_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // AND-OR select of the owner's signals, steered by the registered grant
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_cab   = 1'b0;
    own_adr   = '0;
    own_sel   = '0;
    own_dat   = '0;
    own_dat64 = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) begin
        own_cyc   = bus.req_cyc_i[k];
        own_stb   = bus.req_stb_i[k];
        own_we    = bus.req_we_i[k];
        own_cab   = bus.req_cab_i[k];
        own_adr   = bus.req_adr_i[32*k +: 32];
        own_sel   = bus.req_sel_i[4*k +: 4];
        own_dat   = bus.req_dat_i[32*k +: 32];
        own_dat64 = bus.req_dat64_i[32*k +: 32];
      end
    end
  end

  // cap retry and watchdog error both pre-empt the owner's strobe
  always_comb begin
    in_own      = (state_q == OWN);
    own_busy    = in_own && own_cyc && own_stb;
    others_wait = |(bus.req_cyc_i & ~gnt_q);
    cap_hit     = (beat_q >= BEAT_W'(MAX_BEATS)) && others_wait;
    tmo_fire    = own_busy && (wdog_q >= WDOG_W'(TMO_CYC));
    cap_fire    = own_busy && cap_hit && !tmo_fire;
    stb_out     = own_busy && !tmo_fire && !cap_fire;
    term        = bus.wbm_ack_i || bus.wbm_err_i || bus.wbm_rty_i;
  end

  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req_cyc_i) state_d = OWN;
      OWN:     if (!own_cyc || cap_fire || tmo_fire) state_d = GAP;
      GAP:     state_d = (|bus.req_cyc_i) ? OWN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output decode: master port, terminations to the owner only, read data broadcast
  always_comb begin
    bus.wbm_cyc_o   = in_own && own_cyc && !cap_fire && !tmo_fire;
    bus.wbm_stb_o   = stb_out;
    bus.wbm_we_o    = own_we;
    bus.wbm_cab_o   = own_cab;
    bus.wbm_adr_o   = own_adr;
    bus.wbm_sel_o   = own_sel;
    bus.wbm_dat_o   = own_dat;
    bus.wbm_dat64_o = own_dat64;
    bus.req_gnt_o   = gnt_q;
    bus.req_ack_o   = gnt_q & {N_REQ{stb_out && bus.wbm_ack_i}};
    bus.req_err_o   = gnt_q & {N_REQ{(stb_out && bus.wbm_err_i) || tmo_fire}};
    bus.req_rty_o   = gnt_q & {N_REQ{(stb_out && bus.wbm_rty_i) || cap_fire}};
    bus.req_dat_o   = bus.wbm_dat_i;
    bus.req_dat64_o = bus.wbm_dat64_i;
    arb_tmo_o       = tmo_q;
  end

  // grant, beat counter, watchdog and sticky timeout next values
  always_comb begin
    gnt_d  = '0;
    last_d = last_q;
    if (state_d == OWN) begin
      if (state_q == OWN) begin
        gnt_d = gnt_q;
      end else begin
        gnt_d  = pick;
        last_d = pick;
      end
    end

    beat_d = '0;
    if (in_own) begin
      beat_d = beat_q;
      if (stb_out && bus.wbm_ack_i && (beat_q != '1)) beat_d = beat_q + 1'b1;
    end

    wdog_d = '0;
    if (in_own) begin
      wdog_d = wdog_q;
      if (stb_out && term)                  wdog_d = '0;
      else if (stb_out && (wdog_q != '1))   wdog_d = wdog_q + 1'b1;
    end

    tmo_d = tmo_q;
    if (tmo_fire)       tmo_d = 1'b1;
    else if (tmo_clr_i) tmo_d = 1'b0;
  end

  // datapath registers; last resets to the top index so requester 0 wins first
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gnt_q  <= '0;
      last_q <= {1'b1, {(N_REQ-1){1'b0}}};
      beat_q <= '0;
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      beat_q <= beat_d;
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

endmodule

// File: tb/tb_adma_wbm_arb.sv
// Directed bench for adma_wbm_arb: grant latency, round robin, beat cap,
// watchdog, async reset and retry routing.
module tb_adma_wbm_arb;
  import adma_pkg::*;

  logic clk;
  logic rst;
  logic tmo_clr;
  logic arb_tmo;

  int checks;
  int errors;

  adma_wbm_arb_if #(.N_REQ(3)) bus ();

  adma_wbm_arb #(.N_REQ(3), .MAX_BEATS(16), .TMO_CYC(255)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .tmo_clr_i (tmo_clr),
    .arb_tmo_o (arb_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_cyc_i   = '0;
    bus.req_stb_i   = '0;
    bus.req_we_i    = '0;
    bus.req_cab_i   = '0;
    bus.req_adr_i   = '0;
    bus.req_sel_i   = '0;
    bus.req_dat_i   = '0;
    bus.req_dat64_i = '0;
    bus.wbm_ack_i   = 1'b0;
    bus.wbm_err_i   = 1'b0;
    bus.wbm_rty_i   = 1'b0;
    bus.wbm_dat_i   = '0;
    bus.wbm_dat64_i = '0;
    tmo_clr         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", bus.req_gnt_o); end
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_cab_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_cab_o});
    end
    checks++;
    if ({bus.wbm_adr_o, bus.wbm_sel_o, bus.wbm_dat_o, bus.wbm_dat64_o} !== '0) begin
      errors++; $display("FAIL reset_data got adr %h sel %h exp 0", bus.wbm_adr_o, bus.wbm_sel_o);
    end
    checks++;
    if ({bus.req_ack_o, bus.req_err_o, bus.req_rty_o, arb_tmo} !== 10'd0) begin
      errors++; $display("FAIL reset_term got %b exp 0", {bus.req_ack_o, bus.req_err_o, bus.req_rty_o, arb_tmo});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b000) begin errors++; $display("FAIL idle_no_req_gnt got %b exp 000", bus.req_gnt_o); end
  endtask

  task automatic test_single_read();
    int n_ack;
    n_ack = 0;
    bus.req_cyc_i[REQ_SRC] = 1'b1;
    bus.req_stb_i[REQ_SRC] = 1'b1;
    bus.req_adr_i[63:32]   = 32'h0000_1000;
    #1;
    checks++;
    if (bus.req_gnt_o !== 3'b000) begin errors++; $display("FAIL single_gnt_early got %b exp 000", bus.req_gnt_o); end
    tick();
    bus.wbm_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_adr_i[63:32] = 32'h0000_1000 + 32'(8 * i);
      bus.wbm_dat_i        = 32'h50 + 32'(i);
      #1;
      if (i == 0) begin
        checks++;
        if (bus.req_gnt_o !== 3'b010 || bus.wbm_cyc_o !== 1'b1) begin
          errors++; $display("FAIL single_gnt got %b cyc %b exp 010 cyc 1", bus.req_gnt_o, bus.wbm_cyc_o);
        end
      end
      if (bus.req_ack_o === 3'b010) n_ack++;
      checks++;
      if (bus.req_dat_o !== 32'h50 + 32'(i) || bus.wbm_adr_o !== 32'h0000_1000 + 32'(8 * i)) begin
        errors++; $display("FAIL single_beat%0d got dat %h adr %h exp dat %h", i, bus.req_dat_o, bus.wbm_adr_o, 32'h50 + 32'(i));
      end
      tick();
    end
    checks++;
    if (n_ack != 4) begin errors++; $display("FAIL single_ack_count got %0d exp 4", n_ack); end
    clear_inputs();
    #1;
    checks++;
    if (bus.wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL single_release_cyc got %b exp 0", bus.wbm_cyc_o); end
    tick();
    tick();
  endtask

  task automatic test_two_req();
    do_reset();
    bus.req_cyc_i         = 3'b101;
    bus.req_stb_i         = 3'b101;
    bus.req_adr_i[31:0]   = 32'h0000_0100;
    bus.req_adr_i[95:64]  = 32'h0000_0200;
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b001 || bus.wbm_adr_o !== 32'h100) begin
      errors++; $display("FAIL two_first_gnt got %b adr %h exp 001 adr 100", bus.req_gnt_o, bus.wbm_adr_o);
    end
    bus.wbm_ack_i = 1'b1;
    #1;
    checks++;
    if (bus.req_ack_o !== 3'b001) begin errors++; $display("FAIL two_ack_route got %b exp 001", bus.req_ack_o); end
    tick();
    bus.wbm_ack_i = 1'b0;
    bus.req_cyc_i = 3'b100;
    bus.req_stb_i = 3'b100;
    #1;
    checks++;
    if (bus.wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL two_low1 got cyc %b exp 0", bus.wbm_cyc_o); end
    tick();
    checks++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.req_gnt_o !== 3'b000) begin
      errors++; $display("FAIL two_gap got cyc %b gnt %b exp 0 000", bus.wbm_cyc_o, bus.req_gnt_o);
    end
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b100 || bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h200) begin
      errors++; $display("FAIL two_second_gnt got %b cyc %b adr %h exp 100 1 200", bus.req_gnt_o, bus.wbm_cyc_o, bus.wbm_adr_o);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_beat_cap();
    int n_ack;
    int n_rty;
    do_reset();
    bus.req_cyc_i = 3'b110;
    bus.req_stb_i = 3'b110;
    bus.wbm_ack_i = 1'b1;
    tick();
    n_ack = 0;
    n_rty = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.req_ack_o === 3'b010) n_ack++;
      if (bus.req_rty_o !== 3'b000) n_rty++;
      tick();
    end
    checks++;
    if (n_ack != 16 || n_rty != 0) begin errors++; $display("FAIL cap_first16 got ack %0d rty %0d exp 16 0", n_ack, n_rty); end
    checks++;
    if (bus.req_rty_o !== 3'b010 || bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.req_ack_o !== 3'b000) begin
      errors++; $display("FAIL cap_retry got rty %b cyc %b stb %b ack %b exp 010 0 0 000",
                         bus.req_rty_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.req_ack_o);
    end
    bus.req_cyc_i = 3'b100;
    bus.req_stb_i = 3'b100;
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b000 || bus.req_ack_o !== 3'b000) begin
      errors++; $display("FAIL cap_gap got gnt %b ack %b exp 000 000", bus.req_gnt_o, bus.req_ack_o);
    end
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b100) begin errors++; $display("FAIL cap_handover got %b exp 100", bus.req_gnt_o); end
    bus.req_cyc_i = 3'b110;
    bus.req_stb_i = 3'b110;
    n_ack = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.req_ack_o === 3'b100) n_ack++;
      tick();
    end
    checks++;
    if (n_ack != 2) begin errors++; $display("FAIL cap_dst_beats got %0d exp 2", n_ack); end
    bus.req_cyc_i = 3'b010;
    bus.req_stb_i = 3'b010;
    tick();
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b010) begin errors++; $display("FAIL cap_regrant got %b exp 010", bus.req_gnt_o); end
    n_ack = 0;
    n_rty = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (bus.req_ack_o === 3'b010) n_ack++;
      if (bus.req_rty_o !== 3'b000) n_rty++;
      tick();
    end
    checks++;
    if (n_ack != 24 || n_rty != 0) begin errors++; $display("FAIL cap_rest24 got ack %0d rty %0d exp 24 0", n_ack, n_rty); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int n_stb;
    bus.req_cyc_i[REQ_DESC] = 1'b1;
    bus.req_stb_i[REQ_DESC] = 1'b1;
    tick();
    n_stb = 0;
    for (int i = 0; i < 255; i++) begin
      #1;
      if (bus.wbm_stb_o === 1'b1 && bus.req_err_o === 3'b000) n_stb++;
      tick();
    end
    checks++;
    if (n_stb != 255) begin errors++; $display("FAIL wdog_wait got %0d exp 255", n_stb); end
    checks++;
    if (bus.req_err_o !== 3'b001 || bus.wbm_cyc_o !== 1'b0 || arb_tmo !== 1'b0) begin
      errors++; $display("FAIL wdog_fire got err %b cyc %b tmo %b exp 001 0 0", bus.req_err_o, bus.wbm_cyc_o, arb_tmo);
    end
    tick();
    bus.req_cyc_i = '0;
    bus.req_stb_i = '0;
    checks++;
    if (arb_tmo !== 1'b1 || bus.req_gnt_o !== 3'b000 || bus.req_err_o !== 3'b000) begin
      errors++; $display("FAIL wdog_flag got tmo %b gnt %b err %b exp 1 000 000", arb_tmo, bus.req_gnt_o, bus.req_err_o);
    end
    tick();
    checks++;
    if (arb_tmo !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b exp 1", arb_tmo); end
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    checks++;
    if (arb_tmo !== 1'b0) begin errors++; $display("FAIL wdog_clear got %b exp 0", arb_tmo); end
  endtask

  task automatic test_reset_mid();
    bus.req_cyc_i[REQ_SRC] = 1'b1;
    bus.req_stb_i[REQ_SRC] = 1'b1;
    bus.req_we_i[REQ_SRC]  = 1'b1;
    bus.req_sel_i[7:4]     = 4'hF;
    tick();
    bus.wbm_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_dat_i[63:32] = 32'hA0 + 32'(i);
      tick();
    end
    bus.req_dat_i[63:32] = 32'hA3;
    #1;
    checks++;
    if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_we_o !== 1'b1 || bus.wbm_dat_o !== 32'hA3 || bus.wbm_sel_o !== 4'hF) begin
      errors++; $display("FAIL rstmid_write got cyc %b we %b dat %h sel %h exp 1 1 a3 f",
                         bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_dat_o, bus.wbm_sel_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.req_gnt_o, bus.req_ack_o} !== 9'd0 ||
        bus.wbm_dat_o !== 32'd0 || bus.wbm_sel_o !== 4'd0) begin
      errors++; $display("FAIL rstmid_drop got cyc %b we %b gnt %b ack %b dat %h exp all 0",
                         bus.wbm_cyc_o, bus.wbm_we_o, bus.req_gnt_o, bus.req_ack_o, bus.wbm_dat_o);
    end
    bus.wbm_ack_i = 1'b0;
    tick();
    rst = 1'b0;
    bus.req_cyc_i = 3'b111;
    bus.req_stb_i = 3'b111;
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b001) begin errors++; $display("FAIL rstmid_first got %b exp 001", bus.req_gnt_o); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_rty();
    bus.req_cyc_i[REQ_DST] = 1'b1;
    bus.req_stb_i[REQ_DST] = 1'b1;
    tick();
    bus.wbm_rty_i = 1'b1;
    #1;
    checks++;
    if (bus.req_rty_o !== 3'b100 || bus.req_ack_o !== 3'b000) begin
      errors++; $display("FAIL rty_route got rty %b ack %b exp 100 000", bus.req_rty_o, bus.req_ack_o);
    end
    tick();
    bus.wbm_rty_i = 1'b0;
    tick();
    checks++;
    if (bus.req_gnt_o !== 3'b100 || bus.wbm_cyc_o !== 1'b1) begin
      errors++; $display("FAIL rty_keep got gnt %b cyc %b exp 100 1", bus.req_gnt_o, bus.wbm_cyc_o);
    end
    bus.req_stb_i[REQ_DST] = 1'b0;
    bus.wbm_ack_i          = 1'b1;
    #1;
    checks++;
    if (bus.req_ack_o !== 3'b000 || bus.wbm_stb_o !== 1'b0 || bus.wbm_cyc_o !== 1'b1) begin
      errors++; $display("FAIL rty_idle_term got ack %b stb %b cyc %b exp 000 0 1", bus.req_ack_o, bus.wbm_stb_o, bus.wbm_cyc_o);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_two_req();
    test_beat_cap();
    test_watchdog();
    test_reset_mid();
    test_rty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
